// File: rtl/slow_mem_responder.sv
// Fixed-latency 128-bit line memory responder for the cache/memory handshake.
// Optional MEM_STAT_EN build adds saturating completed-read/write counters.
module slow_mem_responder #(
    parameter int unsigned LATENCY = 5,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         proto_err,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
);

    localparam int unsigned Depth   = 2 ** ADDR_W;
    localparam logic [7:0]  CntLoad = 8'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                is_write_q, is_write_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [127:0]        wdata_q, wdata_d;
    logic [127:0]        rdata_q;
    logic                proto_q, proto_d;
    logic                req;
    logic [127:0]        mem_q [Depth];

    // Upper line-address bits alias onto the same lines.
    logic unused_addr;
    assign unused_addr = ^mem_addr[27:ADDR_W];

    assign req = mem_read | mem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        proto_d    = proto_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    // Write wins a read/write collision.
                    is_write_d = mem_write;
                    idx_d      = mem_addr[ADDR_W-1:0];
                    wdata_d    = mem_wdata;
                    cnt_d      = CntLoad;
                    if (mem_read && mem_write) begin
                        proto_d = 1'b1;
                    end
                    state_d = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                if (!req) begin
                    proto_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        mem_ready = (state_q == StResp);
    end

    always_ff @(posedge clk) begin
        cnt_q      <= cnt_d;
        is_write_q <= is_write_d;
        idx_q      <= idx_d;
        wdata_q    <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            proto_q <= 1'b0;
        end else begin
            proto_q <= proto_d;
            if (state_d == StResp && !is_write_d) begin
                rdata_q <= mem_q[idx_d];
            end
        end
    end

    // Commit happens on the edge that ends the ready cycle, unless reset aborts it.
    always_ff @(posedge clk) begin
        if (!rst && state_q == StResp && is_write_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign proto_err = proto_q;

`ifdef MEM_STAT_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (state_q == StResp) begin
            if (is_write_q) begin
                if (wr_cnt_q != 16'hFFFF) begin
                    wr_cnt_q <= wr_cnt_q + 16'd1;
                end
            end else if (rd_cnt_q != 16'hFFFF) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = 16'd0;
    assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_slow_mem_responder.sv
// Bench for slow_mem_responder: transaction-level model checked every cycle,
// plus a LATENCY=1 instance exercised with directed vectors.
`timescale 1ns/1ps
module tb_slow_mem_responder;

    localparam int unsigned LAT   = 5;
    localparam int unsigned AW    = 10;
    localparam longint      NEVER = 64'sh7FFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready, proto_err;
    logic [15:0]  rd_count, wr_count;

    logic         f_read, f_write;
    logic [27:0]  f_addr;
    logic [127:0] f_wdata, f_rdata;
    logic         f_ready, f_proto;
    logic [15:0]  f_rd_count, f_wr_count;

    slow_mem_responder #(.LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .proto_err (proto_err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    slow_mem_responder #(.LATENCY(1), .ADDR_W(AW)) fdut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (f_read),
        .mem_write (f_write),
        .mem_addr  (f_addr),
        .mem_wdata (f_wdata),
        .mem_rdata (f_rdata),
        .mem_ready (f_ready),
        .proto_err (f_proto),
        .rd_count  (f_rd_count),
        .wr_count  (f_wr_count)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: line contents, the one outstanding transaction and when it must complete.
    logic [127:0] model_mem [int];
    longint       pend_cycle;
    bit           pend_write;
    int           pend_idx;
    logic [127:0] pend_wdata;
    logic [127:0] exp_rdata;
    longint       proto_cycle;
    int           exp_rd, exp_wr;
    bit           chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit due;
        if (chk_en) begin
            due = (cyc == pend_cycle);
            if (due && !pend_write) begin
                exp_rdata = model_mem.exists(pend_idx) ? model_mem[pend_idx] : 128'h0;
            end
            check("mem_ready", {127'b0, mem_ready}, {127'b0, due});
            check("mem_rdata", mem_rdata, exp_rdata);
            check("proto_err", {127'b0, proto_err}, {127'b0, (cyc >= proto_cycle)});
`ifdef MEM_STAT_EN
            check("rd_count", {112'b0, rd_count}, 128'(exp_rd));
            check("wr_count", {112'b0, wr_count}, 128'(exp_wr));
`else
            check("rd_count", {112'b0, rd_count}, 128'h0);
            check("wr_count", {112'b0, wr_count}, 128'h0);
`endif
            if (due) begin
                if (pend_write) begin
                    model_mem[pend_idx] = pend_wdata;
                    if (exp_wr < 65535) exp_wr++;
                end else if (exp_rd < 65535) begin
                    exp_rd++;
                end
                pend_cycle = -1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        chk_en    = 1'b0;
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst         = 1'b0;
        pend_cycle  = -1;
        exp_rdata   = '0;
        proto_cycle = NEVER;
        exp_rd      = 0;
        exp_wr      = 0;
        check("rst_ready", {127'b0, mem_ready}, 128'h0);
        check("rst_rdata", mem_rdata, 128'h0);
        check("rst_proto", {127'b0, proto_err}, 128'h0);
        check("rst_counts", {96'b0, rd_count, wr_count}, 128'h0);
        chk_en = 1'b1;
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [27:0] addr,
                          input logic [127:0] wd, input bit scramble,
                          output longint t_req, output longint t_rdy);
        @(negedge clk);
        mem_read   = rd;
        mem_write  = wr;
        mem_addr   = addr;
        mem_wdata  = wd;
        t_req      = cyc;
        pend_cycle = cyc + LAT;
        pend_write = wr;
        pend_idx   = int'(addr[AW-1:0]);
        pend_wdata = wd;
        if (rd && wr && proto_cycle > cyc + 1) proto_cycle = cyc + 1;
        t_rdy = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (scramble && i == 1) begin
                mem_addr  = ~addr;
                mem_wdata = ~wd;
            end
            if (mem_ready) begin
                t_rdy = cyc;
                break;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check("req_completed", {127'b0, (t_rdy >= 0)}, 128'h1);
    endtask

    task automatic f_req(input bit wr, input logic [27:0] addr, input logic [127:0] wd,
                         input logic [127:0] exp_rd_data);
        @(negedge clk);
        f_read  = !wr;
        f_write = wr;
        f_addr  = addr;
        f_wdata = wd;
        check("f_ready_idle", {127'b0, f_ready}, 128'h0);
        @(negedge clk);
        check("f_ready_next", {127'b0, f_ready}, 128'h1);
        if (!wr) check("f_rdata", f_rdata, exp_rd_data);
        f_read  = 1'b0;
        f_write = 1'b0;
        @(negedge clk);
        check("f_ready_off", {127'b0, f_ready}, 128'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint       tq, tr, tq2, tr2;
        logic [127:0] pat_a5, pat_w7;
        pat_a5 = {16{8'hA5}};
        pat_w7 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        f_read = 1'b0; f_write = 1'b0; f_addr = '0; f_wdata = '0;
        pend_cycle = -1; proto_cycle = NEVER; exp_rdata = '0; exp_rd = 0; exp_wr = 0;
        do_reset();

        // Preload through the port.
        do_req(1'b0, 1'b1, 28'h9, 128'h0, 1'b0, tq, tr);
        do_req(1'b0, 1'b1, 28'h3, pat_a5, 1'b0, tq, tr);

        do_req(1'b1, 1'b0, 28'h3, '0, 1'b0, tq, tr);
        check("read3_latency", 128'(tr - tq), 128'd5);
        check("read3_data", mem_rdata, pat_a5);

        // Write with mid-wait address/data churn, then back-to-back read.
        do_req(1'b0, 1'b1, 28'h7, pat_w7, 1'b1, tq, tr);
        do_req(1'b1, 1'b0, 28'h7, '0, 1'b0, tq2, tr2);
        check("b2b_spacing", 128'(tr2 - tr), 128'd6);
        check("b2b_data", mem_rdata, pat_w7);
        check("b2b_proto", {127'b0, proto_err}, 128'h0);

        do_req(1'b1, 1'b0, 28'h0000407, '0, 1'b0, tq, tr);
        check("alias_data", mem_rdata, pat_w7);

        // Read+write collision: write wins.
        do_req(1'b1, 1'b1, 28'h2, 128'h1, 1'b0, tq, tr);
        check("collide_rdata_kept", mem_rdata, pat_w7);
        do_req(1'b1, 1'b0, 28'h2, '0, 1'b0, tq, tr);
        check("collide_line2", mem_rdata, 128'h1);
        check("collide_proto", {127'b0, proto_err}, 128'h1);

        // Request dropped after two wait cycles.
        do_reset();
        @(negedge clk);
        mem_read = 1'b1; mem_addr = 28'h3;
        pend_cycle = cyc + LAT; pend_write = 1'b0; pend_idx = 3;
        repeat (3) @(negedge clk);
        mem_read    = 1'b0;
        pend_cycle  = -1;
        proto_cycle = cyc + 1;
        repeat (8) @(negedge clk);
        check("drop_proto", {127'b0, proto_err}, 128'h1);
        check("drop_rdata", mem_rdata, 128'h0);
        do_req(1'b1, 1'b0, 28'h7, '0, 1'b0, tq, tr);
        check("after_drop_latency", 128'(tr - tq), 128'd5);
        check("after_drop_data", mem_rdata, pat_w7);

        // Reset in the middle of a write to line 9.
        @(negedge clk);
        mem_write = 1'b1; mem_addr = 28'h9; mem_wdata = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
        repeat (2) @(negedge clk);
        do_reset();
        do_req(1'b1, 1'b0, 28'h3, '0, 1'b0, tq, tr);
        check("post_rst_line3", mem_rdata, pat_a5);
        do_req(1'b1, 1'b0, 28'h9, '0, 1'b0, tq, tr);
        check("post_rst_line9", mem_rdata, 128'h0);

        // LATENCY=1 instance: 2 writes, 3 reads.
        f_req(1'b1, 28'h1, 128'hAAAA_0001, '0);
        f_req(1'b1, 28'h2, 128'hBBBB_0002, '0);
        f_req(1'b0, 28'h1, '0, 128'hAAAA_0001);
        f_req(1'b0, 28'h2, '0, 128'hBBBB_0002);
        f_req(1'b0, 28'h1, '0, 128'hAAAA_0001);
        check("f_proto", {127'b0, f_proto}, 128'h0);
`ifdef MEM_STAT_EN
        check("f_rd_count", {112'b0, f_rd_count}, 128'd3);
        check("f_wr_count", {112'b0, f_wr_count}, 128'd2);
`else
        check("f_rd_count", {112'b0, f_rd_count}, 128'd0);
        check("f_wr_count", {112'b0, f_wr_count}, 128'd0);
`endif

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
